std_sdiv_pipe: RTL
==================

STD_SDIV_PIPE -- requirements
Module: std_sdiv_pipe

Interface
REQ-001 SHALL have parameter width, default 32, giving the operand and result width in bits; legal range is width >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port go, input, 1 bit: request and hold strobe for a division.
REQ-005 SHALL have port left, input signed, width bits: the dividend.
REQ-006 SHALL have port right, input signed, width bits: the divisor.
REQ-007 SHALL have port out_quotient, output signed, width bits: the registered quotient.
REQ-008 SHALL have port out_remainder, output signed, width bits: the registered remainder.
REQ-009 SHALL have port done, output, 1 bit: a registered completion pulse.

Function
REQ-010 SHALL compute out_quotient = left / right and out_remainder = left % right with truncation toward zero, matching the combinational std_sdiv/std_smod results bit-for-bit.
- Quotient sign = sign(left) XOR sign(right).
- Remainder sign = sign(left); remainder is zero when the division is exact.
REQ-011 SHALL implement an FSM with states IDLE, RUN, FIX and DONE.
REQ-012 SHALL, in IDLE with go=1 at a rising edge:
- capture left and right;
- load the magnitudes |left| and |right| as unsigned width-bit values, so |MIN| = 2^(width-1) is representable;
- enter RUN with the iteration counter at 0.
REQ-013 SHALL, in RUN, perform one restoring shift-subtract step per cycle on an unsigned (width+1)-bit partial remainder, and enter FIX after exactly width steps.
REQ-014 SHALL, in FIX, apply sign correction using two's-complement negation modulo 2^width, load out_quotient and out_remainder, and enter DONE.
REQ-015 SHALL, in DONE, drive done=1 for exactly one cycle and then return to IDLE.
REQ-016 SHALL assert done exactly width+2 rising edges after the edge that sampled go in IDLE, for every operand pair.
REQ-017 SHALL hold out_quotient and out_remainder stable from FIX until the next FIX, or until reset.
REQ-018 SHALL, in RUN or FIX, abort to IDLE if go=0 at a rising edge: outputs unchanged, no done pulse.
REQ-019 SHALL ignore left and right while the FSM is not in IDLE.
REQ-020 SHALL start a new operation only from IDLE; go held high through DONE starts the next operation at the first IDLE edge.
REQ-021 SHALL, when right=0, produce out_quotient = all ones and out_remainder = left, with the same fixed latency (no early exit).
REQ-022 SHALL, for left = MIN and right = -1, produce out_quotient = MIN (wrap) and out_remainder = 0.
REQ-023 SHALL, when left = 0, produce a quotient and remainder of 0 with non-negative sign.

Reset
REQ-024 SHALL, while reset=0 and independent of clk, force:
- the FSM to IDLE;
- done = 0;
- out_quotient = 0 and out_remainder = 0;
- the counter and all internal registers to 0.
REQ-025 SHALL discard any in-flight operation on reset, with no done pulse produced.
REQ-026 SHALL, after reset deasserts, sample go no earlier than the first rising edge at which reset=1.

Verification (width=8 unless stated)
REQ-027 SHALL cover sign quadrants, each checking done at edge 10 (width+2) after the go-sampling edge:
- 7/2 -> 3 r 1;
- -7/2 -> -3 r -1;
- 7/-2 -> -3 r 1;
- -7/-2 -> 3 r -1.
REQ-028 SHALL cover boundaries:
- -128/-1 -> -128 r 0;
- -128/1 -> -128 r 0;
- 5/0 -> 0xFF r 5;
- -5/0 -> 0xFF r -5;
- 0/-3 -> 0 r 0.
REQ-029 SHALL cover abort: start 100/7, drop go at RUN step 3 -> no done, outputs keep the prior result; restart -> 14 r 2 with full latency.
REQ-030 SHALL cover reset mid-operation: assert reset asynchronously at RUN step 4 -> outputs 0 and done 0 immediately; after release, 9/4 -> 2 r 1.
REQ-031 SHALL cover back-to-back operation: go held high across two operations (50/7 then -50/7) -> done pulses at edges 10 and 21, results 7 r 1 then -7 r -1.
REQ-032 SHALL cover random compare, width=32: 10k random pairs including MIN, -1 and 0 -> match the combinational / and % reference models.

Source files
------------

// File: rtl/std_sdiv_pipe.sv
// rtl/std_sdiv_pipe.sv - multi-cycle signed divider (restoring, truncating toward zero)
// One quotient bit per RUN cycle; sign fix-up and result load happen in FIX.
module std_sdiv_pipe #(
  parameter int width = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic signed [width-1:0] left,
  input  logic signed [width-1:0] right,
  output logic signed [width-1:0] out_quotient,
  output logic signed [width-1:0] out_remainder,
  output logic                    done
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [width-1:0] dvd;
  logic [width-1:0] dvs;
  logic [width-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             l_neg;
  logic             r_neg;
  logic             r_zero;

  logic             start;
  logic             run_step;
  logic             fix_load;
  logic             done_set;
  logic             last_step;

  logic [width-1:0] abs_l;
  logic [width-1:0] abs_r;
  logic [width:0]   rem_sh;
  logic [width-1:0] diff;
  logic             ge;

  // Magnitudes are unsigned so that |MIN| = 2^(width-1) fits.
  assign abs_l = left[width-1]  ? (~$unsigned(left)  + width'(1)) : $unsigned(left);
  assign abs_r = right[width-1] ? (~$unsigned(right) + width'(1)) : $unsigned(right);

  assign rem_sh    = {rem, dvd[width-1]};
  assign ge        = (rem_sh >= {1'b0, dvs});
  assign diff      = rem_sh[width-1:0] - dvs;
  assign last_step = (cnt == CW'(width - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = RUN;
      RUN: begin
        if (!go)            state_nxt = IDLE;
        else if (last_step) state_nxt = FIX;
      end
      FIX: begin
        if (!go) state_nxt = IDLE;
        else     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    run_step = 1'b0;
    fix_load = 1'b0;
    done_set = 1'b0;
    case (state)
      IDLE:    start    = go;
      RUN:     run_step = go;
      FIX:     fix_load = go;
      DONE:    done_set = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      l_neg  <= 1'b0;
      r_neg  <= 1'b0;
      r_zero <= 1'b0;
    end else if (start) begin
      dvd    <= abs_l;
      dvs    <= abs_r;
      rem    <= '0;
      cnt    <= '0;
      l_neg  <= left[width-1];
      r_neg  <= right[width-1];
      r_zero <= (right == '0);
    end else if (run_step) begin
      rem <= ge ? diff : rem_sh[width-1:0];
      dvd <= {dvd[width-2:0], ge};
      cnt <= cnt + CW'(1);
    end
  end

  // Divide-by-zero yields all ones regardless of the dividend sign.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (fix_load) begin
      if (r_zero)
        out_quotient <= '1;
      else if (l_neg ^ r_neg)
        out_quotient <= $signed(~dvd + width'(1));
      else
        out_quotient <= $signed(dvd);
      out_remainder <= l_neg ? $signed(~rem + width'(1)) : $signed(rem);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= done_set;
    end
  end

endmodule
